// File: rtl/calc_sequencer.sv
// Calculator sequencer: latches BCD operands on operator/equals keys, converts to binary,
// computes A op B, and converts the result back to BCD for display.
module calc_sequencer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trig,
  input  logic [3:0]            value,
  input  logic [2:0]            op,
  input  logic [DIGITS*4-1:0]   digits,
  output logic                  entry_clr,
  output logic [DIGITS*4-1:0]   display,
  output logic                  neg,
  output logic                  ovf,
  output logic                  busy
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [2*W:0] MaxMag = (2*W+1)'(10**DIGITS - 1);

  typedef enum logic [2:0] {
    StEnterA, StLoadA, StEnterB, StLoadB, StExec, StConv, StResult
  } state_e;

  state_e          state_q, state_d;
  logic            trig_q;
  logic [1:0]      opc_q, opc_d;
  logic [W:0]      a_q, a_d, b_q, b_d, r_q, r_d;
  logic [W-1:0]    snap_q, snap_d, acc_q, acc_d, bin_q, bin_d, bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d, ovf_q, ovf_d, clr_q, clr_d;

  logic            key_ev, do_clear;
  logic [W-1:0]    acc_step, bcd_adj;
  logic signed [2*W:0] a_ext, b_ext, r_calc;
  logic [2*W:0]    abs_r;

  assign key_ev = trig & ~trig_q;

  always_comb begin
    acc_step = acc_q * W'(10) + W'(snap_q[W-1 -: 4]);
    a_ext = {{W{a_q[W]}}, a_q};
    b_ext = {{W{b_q[W]}}, b_q};
    case (opc_q)
      2'd1:    r_calc = a_ext + b_ext;
      2'd2:    r_calc = a_ext - b_ext;
      default: r_calc = a_ext * b_ext;
    endcase
    abs_r = r_calc[2*W] ? -r_calc : r_calc;
    // Double-dabble: add 3 to any digit >= 5 before each shift
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    snap_d   = snap_q;
    acc_d    = acc_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    clr_d    = 1'b0;
    do_clear = 1'b0;

    unique case (state_q)
      StEnterA: begin
        if (key_ev) begin
          if (op == 3'd7) begin
            do_clear = 1'b1;
          end else if (op >= 3'd1 && op <= 3'd3) begin
            opc_d   = op[1:0];
            clr_d   = 1'b1;
            snap_d  = digits;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StLoadA;
          end
        end
      end
      StLoadA, StLoadB: begin
        acc_d  = acc_step;
        snap_d = snap_q << 4;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) begin
          if (state_q == StLoadA) begin
            a_d     = {1'b0, acc_step};
            state_d = StEnterB;
          end else begin
            b_d     = {1'b0, acc_step};
            state_d = StExec;
          end
        end
      end
      StEnterB: begin
        if (key_ev) begin
          if (op == 3'd7) begin
            do_clear = 1'b1;
          end else if (op == 3'd4) begin
            clr_d   = 1'b1;
            snap_d  = digits;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StLoadB;
          end else if (op >= 3'd1 && op <= 3'd3) begin
            opc_d = op[1:0];
          end
        end
      end
      StExec: begin
        r_d     = r_calc[W:0];
        neg_d   = r_calc[2*W];
        ovf_d   = abs_r > MaxMag;
        bin_d   = abs_r[W-1:0];
        bcd_d   = '0;
        cnt_d   = '0;
        state_d = (abs_r > MaxMag) ? StResult : StConv;
      end
      StConv: begin
        bcd_d = {bcd_adj[W-2:0], bin_q[W-1]};
        bin_d = {bin_q[W-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = StResult;
      end
      StResult: begin
        if (key_ev) begin
          if (op == 3'd7) begin
            do_clear = 1'b1;
          end else if (op == 3'd0 && value <= 4'd9) begin
            neg_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = StEnterA;
          end else if (op >= 3'd1 && op <= 3'd3) begin
            if (ovf_q) begin
              do_clear = 1'b1;
            end else begin
              // Chain: the previous result becomes operand A without reconversion
              a_d     = r_q;
              opc_d   = op[1:0];
              clr_d   = 1'b1;
              neg_d   = 1'b0;
              state_d = StEnterB;
            end
          end
        end
      end
      default: state_d = StEnterA;
    endcase

    if (do_clear) begin
      state_d = StEnterA;
      clr_d   = 1'b1;
      a_d     = '0;
      b_d     = '0;
      neg_d   = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEnterA;
      trig_q  <= 1'b0;
      opc_q   <= 2'd1;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      snap_q  <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
      opc_q   <= opc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      clr_q   <= clr_d;
    end
  end

  assign entry_clr = clr_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
  assign busy      = (state_q == StLoadA) || (state_q == StLoadB) ||
                     (state_q == StExec)  || (state_q == StConv);
  assign display   = (state_q != StResult) ? digits :
                     ovf_q ? {DIGITS{4'h9}} : bcd_q;

endmodule
